// File: rtl/lab2_pio_arb_pkg.sv
// Shared types and constants for the PIO write arbiter.
// Optional readback is enabled by defining LAB2_PIO_ARB_READBACK_EN.
package lab2_pio_arb_pkg;

    localparam int unsigned AVM_DATA_W    = 32;
    localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StAck,
        StGap
    } arb_state_e;

endpackage

// File: rtl/lab2_pio_write_arbiter_if.sv
// Avalon-MM bus between the arbiter (master) and the PIO slave.
interface lab2_pio_write_arbiter_if;
    import lab2_pio_arb_pkg::*;

    logic [1:0]            avm_address;
    logic                  avm_chipselect;
    logic                  avm_write_n;
    logic [AVM_DATA_W-1:0] avm_writedata;
    logic [AVM_DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/lab2_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant pointer.
module lab2_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       winner
);

    // Index of the last requester granted; reset to 1 so requester 0 wins a tie first.
    logic last_q;

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
        valid = |req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (take && valid) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/lab2_pio_write_arbiter.sv
// Two-requester arbiter writing a PIO register over Avalon-MM.
// Define LAB2_PIO_ARB_READBACK_EN to add a readback check with a sticky err flag.
module lab2_pio_write_arbiter
    import lab2_pio_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    output logic [1:0]               ack,
    output logic                     grant_id,
    output logic                     busy,
    output logic                     err,
    input  logic                     err_clr,
    lab2_pio_write_arbiter_if.master avm
);

    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  grant_id_q, grant_id_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  take;
    logic                  arb_valid;
    logic                  arb_winner;
    logic [AVM_DATA_W-1:0] data_ext;

    assign data_ext = AVM_DATA_W'(data_q);

    lab2_rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .take   (take),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        state_d            = state_q;
        data_d             = data_q;
        grant_id_d         = grant_id_q;
        gap_cnt_d          = gap_cnt_q;
        take               = 1'b0;
        ack                = 2'b00;
        avm.avm_address    = PIO_DATA_ADDR;
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_writedata  = '0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    take       = 1'b1;
                    data_d     = arb_winner ? wdata1 : wdata0;
                    grant_id_d = arb_winner;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_writedata  = data_ext;
`ifdef LAB2_PIO_ARB_READBACK_EN
                state_d = StRead;
`else
                state_d = StAck;
`endif
            end
            StRead: begin
                avm.avm_chipselect = 1'b1;
                state_d            = StAck;
            end
            StAck: begin
                ack[grant_id_q] = 1'b1;
                gap_cnt_d       = '0;
                state_d         = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            data_q     <= '0;
            grant_id_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign grant_id = grant_id_q;

`ifdef LAB2_PIO_ARB_READBACK_EN
    logic err_q;

    // A mismatch takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == StRead && avm.avm_readdata != data_ext) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{err_clr, avm.avm_readdata};
    assign err           = 1'b0;
`endif

endmodule

// File: doc/lab2_pio_write_arbiter.md
LAB2_PIO_WRITE_ARBITER -- requirements
Module: lab2_pio_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 12: PIO output width in bits.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles enforced after each ack before the next grant; legal range 0..255.
REQ-003 clk  in  1  the only clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  2  per-requester write request; level, held until ack.
REQ-006 wdata0  in  DATA_W  requester 0 value for the PIO.
REQ-007 wdata1  in  DATA_W  requester 1 value for the PIO.
REQ-008 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-009 grant_id  out  1  index of the current or last granted requester.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 err  out  1  sticky readback-mismatch flag.
REQ-012 err_clr  in  1  clears err.
REQ-013 avm_address  out  2  Avalon-MM address to the PIO slave.
REQ-014 avm_chipselect  out  1  Avalon-MM chipselect.
REQ-015 avm_write_n  out  1  Avalon-MM active-low write.
REQ-016 avm_writedata  out  32  Avalon-MM write data.
REQ-017 avm_readdata  in  32  Avalon-MM read data; combinational from the slave in the same cycle.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, ACK and GAP.
REQ-019 In IDLE with req nonzero, the arbiter SHALL grant round-robin: a sole requester wins; if both request, the requester not granted last wins.
REQ-020 On grant, the arbiter SHALL latch the winner's wdata into an internal register, update grant_id and go to WRITE.
REQ-021 WRITE SHALL last 1 cycle with avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={zeros, latched data}.
REQ-022 WRITE SHALL go to READ when readback is enabled, and to ACK otherwise.
REQ-023 READ SHALL last 1 cycle with avm_chipselect=1, avm_write_n=1, avm_address=0.
REQ-024 In READ, err SHALL set when avm_readdata differs from {zeros, latched data}.
REQ-025 ACK SHALL last 1 cycle and assert ack[grant_id]; the arbiter then enters GAP, or IDLE when GAP_CYCLES=0.
REQ-026 GAP SHALL count GAP_CYCLES cycles, then return to IDLE.
REQ-027 Outside WRITE and READ, avm_chipselect SHALL be 0, avm_write_n 1, avm_address 0 and avm_writedata 0.
REQ-028 Latency from req sampled in IDLE (cycle N): WRITE at N+1; ack at N+2 without readback, N+3 with readback.
REQ-029 A req deasserted mid-transaction SHALL NOT abort it; the write completes and ack still pulses.
REQ-030 When err_clr and a mismatch coincide, set SHALL win.
REQ-031 wdata changes after grant SHALL NOT affect the transaction in progress.
REQ-032 The arbiter SHALL perform exactly one write per ack.

Reset
REQ-033 During reset, the FSM SHALL enter IDLE with ack=0, busy=0, err=0, grant_id=0, the last-grant pointer favouring requester 0 next, the gap counter at 0 and the Avalon outputs at their idle values.
REQ-034 A reset asserted mid-transaction SHALL abandon it with no ack, taking effect at the next clock edge.

Configuration
REQ-035 With macro LAB2_PIO_ARB_READBACK_EN defined, the READ state and err logic SHALL be compiled in.
REQ-036 Without LAB2_PIO_ARB_READBACK_EN, WRITE SHALL go directly to ACK, err SHALL be tied to 0, and err_clr and avm_readdata SHALL be ignored.

Structure
REQ-037 The package lab2_pio_arb_pkg SHALL hold the FSM state enum, the PIO data register address constant (0) and the Avalon data width constant (32).
REQ-038 A sub-module lab2_rr_arbiter2 SHALL implement the 2-way round-robin grant and last-grant pointer.

Verification
REQ-039 After reset, req=01 and wdata0=0xA5A: one write of 0x00000A5A to address 0, ack=01 two cycles later (three with readback).
REQ-040 With req=11 held continuously: grants alternate 0,1,0,1 and consecutive acks are separated by at least GAP_CYCLES idle cycles.
REQ-041 With readback enabled and avm_readdata forced to 0x123 for write data 0x124: err=1 and stays set until err_clr; err_clr in a non-mismatch cycle clears it.
REQ-042 With req dropped the cycle after grant: the write and the ack still occur, and no second write follows.
REQ-043 Reset asserted during WRITE: no ack is issued, the next cycle shows idle Avalon outputs, and the next grant goes to requester 0 when both request.
